// File: rtl/addsub_serial.sv
// Chunk-serial WIDTH-bit add/subtract: one CHUNK-bit ripple slice per clock,
// carry held between cycles, start/busy/done handshake with carry/overflow/zero flags.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             x,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_partial;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_c_next;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

  // A start is taken in IDLE and also in FIN, which allows back-to-back operations.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

  // Operands shift right one chunk per cycle, so the slice always reads the low chunk.
  assign w_a_chunk = r_opa[CHUNK-1:0];
  assign w_b_chunk = r_opb[CHUNK-1:0];
  assign {w_c_next, w_sum} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_carry);

  // Sums enter the partial register from the top; after NCHUNK steps it holds the result.
  assign w_result = WIDTH'({w_sum, r_partial} >> CHUNK);

  // Carry-in XOR carry-out of the MSB, expressed via the sign bits of the final slice.
  assign w_ovf = (w_a_chunk[CHUNK-1] ~^ w_b_chunk[CHUNK-1]) &
                 (w_a_chunk[CHUNK-1] ^ w_sum[CHUNK-1]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next-state default is assigned first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST_CNT) w_state_nxt = FIN;
      FIN:     w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_partial <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_opa     <= a;
      r_opb     <= b ^ {WIDTH{x}};
      r_carry   <= x;
      r_cnt     <= '0;
    end else if (r_state == RUN) begin
      r_opa     <= r_opa >> CHUNK;
      r_opb     <= r_opb >> CHUNK;
      r_partial <= w_result;
      r_carry   <= w_c_next;
      r_cnt     <= r_cnt + CW'(1);
    end
  end

  // Visible results update only on the completing edge and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_s    <= w_result;
      r_cout <= w_c_next;
      r_ovf  <= w_ovf;
      r_zero <= (w_result == '0);
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
  assign busy = (r_state == RUN);
  assign done = (r_state == FIN);

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: three instances (CHUNK = 4, 16, 1) share operands;
// the driver queues expected results, per-instance monitors check them on each done pulse.
module tb_addsub_serial;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           done_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [2:0]   start_v;
  logic         x;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s_v    [3];
  logic         cout_v [3];
  logic         ovf_v  [3];
  logic         zero_v [3];
  logic         busy_v [3];
  logic         done_v [3];

  exp_t q [3][$];
  int   cyc;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nchunk(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CH = (gi == 0) ? 4 : (gi == 1) ? 16 : 1;
    addsub_serial #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[gi]),
      .x     (x),
      .a     (a),
      .b     (b),
      .s     (s_v[gi]),
      .cout  (cout_v[gi]),
      .ovf   (ovf_v[gi]),
      .zero  (zero_v[gi]),
      .busy  (busy_v[gi]),
      .done  (done_v[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every done pulse must match the oldest queued expectation, at the predicted cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n === 1'b1 && done_v[gi] === 1'b1) begin
        if (q[gi].size() == 0) begin
          check($sformatf("u%0d unexpected done", gi), 32'(done_v[gi]), 32'd0);
        end else begin
          e = q[gi].pop_front();
          check($sformatf("u%0d s", gi),         32'(s_v[gi]),    32'(e.s));
          check($sformatf("u%0d cout", gi),      32'(cout_v[gi]), 32'(e.cout));
          check($sformatf("u%0d ovf", gi),       32'(ovf_v[gi]),  32'(e.ovf));
          check($sformatf("u%0d zero", gi),      32'(zero_v[gi]), 32'(e.zero));
          check($sformatf("u%0d done cycle", gi), 32'(cyc),       32'(e.done_cyc));
        end
      end
    end
  end

  task automatic push_exp(input int idx, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez, input int dcyc);
    exp_t e;
    e.s = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.done_cyc = dcyc;
    q[idx].push_back(e);
  endtask

  // Start accepted at the next posedge; done is seen NCHUNK edges after that.
  task automatic issue(input int idx, input logic xx, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] es,
                       input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    x = xx; a = aa; b = bb;
    start_v[idx] = 1'b1;
    push_exp(idx, es, ec, eo, ez, cyc + 1 + nchunk(idx));
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    for (int k = 0; k < 40; k++) begin
      if (q[idx].size() == 0) break;
      @(negedge clk);
    end
    if (q[idx].size() != 0) begin
      check($sformatf("u%0d timeout pending", idx), 32'(q[idx].size()), 32'd0);
      q[idx].delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int idx, input logic xx, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input logic [W-1:0] es,
                     input logic ec, input logic eo, input logic ez);
    issue(idx, xx, aa, bb, es, ec, eo, ez);
    wait_idle(idx);
  endtask

  initial begin
    int k0;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start_v = '0;
    x = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d reset s/flags", i),
            {12'd0, s_v[i], cout_v[i], ovf_v[i], zero_v[i], busy_v[i], done_v[i]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // CHUNK=4 functional vectors.
    issue(0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
    check("u0 busy after start", 32'(busy_v[0]), 32'd1);
    wait_idle(0);
    run(0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run(0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1);
    run(0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    run(0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run(0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Start during RUN with new operands must be ignored.
    issue(0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
    x = 1'b1; a = 16'hFFFF; b = 16'hFFFF; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);

    // Start held through FIN: second op back-to-back, done pulses NCHUNK+1 edges apart.
    @(negedge clk);
    k0 = cyc;
    x = 1'b0; a = 16'h0001; b = 16'h0002; start_v[0] = 1'b1;
    push_exp(0, 16'h0003, 1'b0, 1'b0, 1'b0, k0 + 1 + 4);
    @(negedge clk);
    x = 1'b1; a = 16'h0010; b = 16'h0001;
    push_exp(0, 16'h000F, 1'b1, 1'b0, 1'b0, k0 + 2 + 8);
    repeat (5) @(negedge clk);
    start_v[0] = 1'b0;
    check("u0 s held during 2nd op", 32'(s_v[0]), 32'h0003);
    check("u0 busy in 2nd op", 32'(busy_v[0]), 32'd1);
    wait_idle(0);

    // Asynchronous reset in the second RUN cycle: everything clears, no done follows.
    run(0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    issue(0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("u0 s after async reset", 32'(s_v[0]), 32'd0);
    check("u0 flags after async reset",
          {27'd0, cout_v[0], ovf_v[0], zero_v[0], busy_v[0], done_v[0]}, 32'd0);
    q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run(0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);

    // CHUNK=16 (single pass) and CHUNK=1 (bit-serial) re-runs.
    for (int d = 1; d < 3; d++) begin
      run(d, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
      run(d, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
      run(d, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      run(d, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
